// File: rtl/shift_reg_univ.sv
// Universal shift register: shift/rotate in either direction, parallel load and read-out.
// word_done pulses for one cycle after every WIDTH shift/rotate operations.
module shift_reg_univ #(
  parameter int                 WIDTH     = 8,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0,
  localparam int                CW        = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             s_in,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] q,
  output logic             s_out,
  output logic [CW-1:0]    shift_cnt,
  output logic             word_done
);

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_SL   = 3'b001;
  localparam logic [2:0] M_SR   = 3'b010;
  localparam logic [2:0] M_RL   = 3'b011;
  localparam logic [2:0] M_RR   = 3'b100;
  localparam logic [2:0] M_LOAD = 3'b101;

  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             is_shift;

  always_comb begin
    q_d      = q_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    is_shift = 1'b0;
    if (en) begin
      case (mode)
        M_SL:   begin q_d = {q_q[WIDTH-2:0], s_in};     is_shift = 1'b1; end
        M_SR:   begin q_d = {s_in, q_q[WIDTH-1:1]};     is_shift = 1'b1; end
        M_RL:   begin q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]}; is_shift = 1'b1; end
        M_RR:   begin q_d = {q_q[0], q_q[WIDTH-1:1]};   is_shift = 1'b1; end
        M_LOAD: begin q_d = d_in; cnt_d = '0; end
        default: ;
      endcase
      // Any direction counts toward the word; wrap raises the pulse for the next cycle.
      if (is_shift) begin
        if (cnt_q == CW'(WIDTH - 1)) begin
          cnt_d  = '0;
          done_d = 1'b1;
        end else begin
          cnt_d  = cnt_q + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      q_q    <= RESET_VAL;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  // Bit that would leave next: MSB for left moves, LSB otherwise.
  assign s_out     = (mode == M_SL || mode == M_RL) ? q_q[WIDTH-1] : q_q[0];
  assign q         = q_q;
  assign shift_cnt = cnt_q;
  assign word_done = done_q;

endmodule

// File: tb/tb_shift_reg_univ.sv
// Directed bench for shift_reg_univ (WIDTH=8), with a second instance for RESET_VAL=0x5A.
module tb_shift_reg_univ;

  logic       clk = 1'b0;
  logic       reset, en, s_in;
  logic [2:0] mode;
  logic [7:0] d_in;
  logic [7:0] q, q2;
  logic       s_out, s_out2, word_done, word_done2;
  logic [2:0] shift_cnt, shift_cnt2;

  int n_pass  = 0;
  int n_total = 0;

  localparam logic [2:0] HOLD = 3'b000, SL = 3'b001, SR = 3'b010,
                         RL = 3'b011, RR = 3'b100, LOAD = 3'b101;

  always #5 clk = ~clk;

  shift_reg_univ #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .s_in(s_in), .d_in(d_in),
    .q(q), .s_out(s_out), .shift_cnt(shift_cnt), .word_done(word_done));

  shift_reg_univ #(.WIDTH(8), .RESET_VAL(8'h5A)) dut5a (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .s_in(s_in), .d_in(d_in),
    .q(q2), .s_out(s_out2), .shift_cnt(shift_cnt2), .word_done(word_done2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_state(input string tag, input logic [7:0] eq, input logic [2:0] ecnt,
                           input logic edone);
    chk({tag, ".q"}, 32'(q), 32'(eq));
    chk({tag, ".cnt"}, 32'(shift_cnt), 32'(ecnt));
    chk({tag, ".done"}, 32'(word_done), 32'(edone));
  endtask

  initial begin
    logic [7:0] pat;
    logic [7:0] exp_so;
    // 1: reset wins over an active SL
    reset = 1'b0; en = 1'b1; mode = SL; s_in = 1'b1; d_in = 8'h00;
    tick(); tick();
    chk_state("rst", 8'h00, 3'd0, 1'b0);
    chk("rst.q5a", 32'(q2), 32'h5A);

    // 2: shift in 1,1,0,0,1,1,0,0 -> 0xCC with a single pulse
    reset = 1'b1;
    pat = 8'b1100_1100;
    for (int i = 0; i < 8; i++) begin
      s_in = pat[7-i];
      tick();
      chk("sl8.done", 32'(word_done), (i == 7) ? 32'd1 : 32'd0);
      chk("sl8.cnt", 32'(shift_cnt), 32'((i + 1) % 8));
    end
    chk("sl8.q", 32'(q), 32'hCC);
    chk("sl8.sout_sl", 32'(s_out), 32'd1);
    mode = HOLD;
    #1 chk("sl8.sout_hold", 32'(s_out), 32'd0);
    tick();
    chk_state("sl8.after", 8'hCC, 3'd0, 1'b0);

    // 3: load then SR; s_out is LSB before each edge
    mode = LOAD; d_in = 8'hA5;
    tick();
    chk_state("ld_a5", 8'hA5, 3'd0, 1'b0);
    mode = SR; s_in = 1'b0;
    exp_so = 8'b0000_0101;
    for (int i = 0; i < 4; i++) begin
      #1 chk("sr.sout", 32'(s_out), 32'(exp_so[i]));
      tick();
    end
    chk_state("sr4", 8'h0A, 3'd4, 1'b0);

    // 4: rotates
    mode = LOAD; d_in = 8'h81; tick();
    mode = RL; tick();
    chk("rl1.q", 32'(q), 32'h03);
    mode = LOAD; tick();
    mode = RR; tick();
    chk("rr1.q", 32'(q), 32'hC0);
    mode = LOAD; tick();
    mode = RL;
    for (int i = 0; i < 7; i++) tick();
    chk_state("rl7", 8'hC0, 3'd7, 1'b0);
    tick();
    chk_state("rl8", 8'h81, 3'd0, 1'b1);

    // 5: enable gating mid-word
    mode = LOAD; d_in = 8'h00; tick();
    mode = SL; s_in = 1'b1;
    tick(); tick(); tick();
    chk_state("en.pre", 8'h07, 3'd3, 1'b0);
    en = 1'b0;
    tick();
    chk_state("en.off1", 8'h07, 3'd3, 1'b0);
    tick();
    chk_state("en.off2", 8'h07, 3'd3, 1'b0);
    en = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk_state("en.sl7", 8'h7F, 3'd7, 1'b0);
    tick();
    chk_state("en.sl8", 8'hFF, 3'd0, 1'b1);
    en = 1'b0;
    tick();
    chk_state("en.clr", 8'hFF, 3'd0, 1'b0);
    en = 1'b1;

    // 6: reset and load abort partial words without a pulse
    mode = LOAD; d_in = 8'h00; tick();
    mode = SL; s_in = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk_state("ab.sl5", 8'h1F, 3'd5, 1'b0);
    reset = 1'b0;
    tick();
    chk_state("ab.rst", 8'h00, 3'd0, 1'b0);
    chk("ab.rst5a", 32'(q2), 32'h5A);
    reset = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    chk_state("ab.sl7", 8'h7F, 3'd7, 1'b0);
    mode = LOAD; d_in = 8'hFF;
    tick();
    chk_state("ab.ld", 8'hFF, 3'd0, 1'b0);
    mode = SL; s_in = 1'b0;
    tick();
    chk_state("ab.sl1", 8'hFE, 3'd1, 1'b0);

    // reserved modes hold
    mode = 3'b110; tick();
    chk_state("rsv6", 8'hFE, 3'd1, 1'b0);
    mode = 3'b111; tick();
    chk_state("rsv7", 8'hFE, 3'd1, 1'b0);
    chk("rsv.sout", 32'(s_out), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
